// File: rtl/regbank_arbiter.sv
// regbank_arbiter: round-robin arbitrated write port into a small register bank
// with combinational read, commit pulse, last-writer id and saturating write count.
module regbank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int IW = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   freeze,
    input  logic                   clear,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*AW-1:0]    wr_addr,
    input  logic [N_REQ*WIDTH-1:0] wr_data,
    output logic [N_REQ-1:0]       gnt,
    input  logic [AW-1:0]          rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   wr_done,
    output logic [IW-1:0]          wr_id,
    output logic [7:0]             wr_count
);
    logic [WIDTH-1:0] r_bank [DEPTH];
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    w_sel;
    logic [IW-1:0]    w_cand;
    logic             w_hit;
    logic             w_commit;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic [IW-1:0]    w_ptr_nxt;

    // Scan from the highest offset down so the last hit is the first in round-robin order.
    always_comb begin
        w_sel  = '0;
        w_hit  = 1'b0;
        w_cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = IW'((int'(r_ptr) + k) % N_REQ);
            if (req[w_cand]) begin
                w_sel = w_cand;
                w_hit = 1'b1;
            end
        end
    end

    assign w_commit  = w_hit & ~freeze & ~clear & ~reset;
    assign gnt       = w_commit ? (N_REQ'(1) << w_sel) : '0;
    assign w_addr    = wr_addr[int'(w_sel)*AW +: AW];
    assign w_data    = wr_data[int'(w_sel)*WIDTH +: WIDTH];
    assign w_ptr_nxt = (w_sel == IW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            wr_done  <= 1'b0;
            wr_id    <= '0;
            wr_count <= '0;
        end else begin
            wr_done <= w_commit;
            if (w_commit) begin
                r_ptr    <= w_ptr_nxt;
                wr_id    <= w_sel;
                wr_count <= wr_count + {7'd0, wr_count != 8'hFF};
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_bank
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_bank[g] <= '0;
            else if (clear)
                r_bank[g] <= '0;
            else if (w_commit && w_addr == AW'(g))
                r_bank[g] <= w_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < DEPTH; k++)
            if (rd_addr == AW'(k)) rd_data = r_bank[k];
    end
endmodule

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 The block SHALL take parameter N_REQ, default 4, meaning the number of write requesters (2..8).
REQ-002 The block SHALL take parameter WIDTH, default 4, meaning the data width of each bank register.
REQ-003 The block SHALL take parameter DEPTH, default 4, meaning the number of bank registers; AW = clog2(DEPTH).
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 freeze  input  1  global write hold; while high no grant SHALL issue.
REQ-007 clear  input  1  synchronous bank clear.
REQ-008 req  input  N_REQ  per-requester write request, level.
REQ-009 wr_addr  input  N_REQ*AW  packed target addresses; slice i belongs to requester i.
REQ-010 wr_data  input  N_REQ*WIDTH  packed write data; slice i belongs to requester i.
REQ-011 gnt  output  N_REQ  one-hot combinational grant; the write commits at the next rising edge.
REQ-012 rd_addr  input  AW  read address.
REQ-013 rd_data  output  WIDTH  combinational read of bank[rd_addr].
REQ-014 wr_done  output  1  registered pulse; high for one cycle after each committed write.
REQ-015 wr_id  output  clog2(N_REQ)  registered index of the last committed requester.
REQ-016 wr_count  output  8  registered count of committed writes; saturates at 255.

Function
REQ-017 Bank: DEPTH enabled registers of WIDTH bits; register k SHALL load only at an edge where a grant targets address k and clear is low.
REQ-018 Arbitration: round-robin; the search SHALL start at pointer ptr (width clog2(N_REQ)) and take the first i with req[i]=1, scanning ptr, ptr+1, ... and wrapping modulo N_REQ.
REQ-019 gnt SHALL be zero when freeze=1, clear=1, reset=1 or req=0; otherwise exactly one bit SHALL be set.
REQ-020 A requester SHALL hold req, wr_addr and wr_data stable until it sees its gnt bit; it SHALL drop req after that edge for a single write.
REQ-021 A requester that keeps req high after a grant SHALL be treated as a new request and wait its round-robin turn.
REQ-022 On a committed grant to index i, ptr SHALL become (i+1) mod N_REQ; with no grant, ptr SHALL hold.
REQ-023 Write latency: the data SHALL be visible on rd_data in the cycle after the granting edge, when rd_addr matches.
REQ-024 There is no read/write bypass: rd_data SHALL show the old value during the granting cycle.
REQ-025 clear=1 SHALL zero all bank registers at the edge and SHALL block any grant that cycle; ptr, wr_count and wr_id SHALL hold.
REQ-026 wr_done SHALL be 1 in the cycle after each committed write and 0 otherwise.
REQ-027 wr_id SHALL update only on a commit.
REQ-028 wr_count SHALL increment by 1 per commit and SHALL stay at 255 once reached.
REQ-029 freeze SHALL only block grants; the bank, ptr and counters SHALL hold while it is high, and pending requests SHALL be served after freeze drops.

Reset
REQ-030 While reset is high the block SHALL force the following: bank all 0, ptr=0, wr_done=0, wr_id=0, wr_count=0, gnt=0.
REQ-031 A reset asserted mid-operation SHALL abort the pending grant without any write; arbitration SHALL restart from ptr=0.

Verification
REQ-032 The bench SHALL cover the following directed scenarios.
- Reset, then req=4'b0001, addr0=2, data0=4'hA -> gnt=0001; one cycle later rd_addr=2 gives 4'hA, wr_done=1, wr_id=0, wr_count=1.
- req=4'b1111 held continuously, each requester targeting its own address with data 1/2/3/4 -> grants in order 0,1,2,3,0; wr_count reaches 5.
- freeze=1 with req=4'b0100 for 3 cycles -> gnt=0, bank unchanged; freeze=0 -> gnt=0100 in that same cycle.
- Bank loaded with 4'hF everywhere, then clear=1 while req=4'b0010 -> gnt=0, all reads 0; next cycle gnt=0010 and the write commits.
- reset pulsed 3 ns during an active grant -> no write, outputs 0, next grant goes to the lowest-index requester.
- 260 single writes -> wr_count=255 and holds.
